mp2_frame_ctrl: RTL



---
 rtl/mp2_frame_ctrl_pkg.sv | 30 +++
 rtl/mp2_buf_credit.sv | 96 +++++++++
 rtl/mp2_frame_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mp2_frame_ctrl_pkg.sv
// Shared definitions for the MP2 frame sequencer: state encoding, shift codes,
// default granule/buffer counts and the buffer-index rotation helper.
package mp2_frame_ctrl_pkg;

  localparam int MP2_NUM_GRAN_DEF = 12;
  localparam int MP2_NUM_BUF_DEF  = 2;

  typedef enum logic [3:0] {
    MP2_FRAME_IDLE,
    MP2_FRAME_HDR_GO,
    MP2_FRAME_HDR_WAIT,
    MP2_FRAME_ALLOC_GO,
    MP2_FRAME_ALLOC_WAIT,
    MP2_FRAME_SCF_GO,
    MP2_FRAME_SCF_WAIT,
    MP2_FRAME_GRAN,
    MP2_FRAME_DRAIN
  } mp2_frame_state_t;

  typedef enum logic [1:0] {
    MP2_SHIFT_NONE = 2'b00,
    MP2_SHIFT_ONE  = 2'b01,
    MP2_SHIFT_TWO  = 2'b10
  } mp2_shift_t;

  function automatic logic [1:0] mp2_buf_next(input logic [1:0] idx, input logic [1:0] last);
    return (idx >= last) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/mp2_buf_credit.sv
// Two-sided buffer credit between sample decode and synthesis: free/filled
// counters, per-side buffer index rotation, granule counts and start qualification.
module mp2_buf_credit
  import mp2_frame_ctrl_pkg::*;
#(
  parameter int NUM_GRAN = MP2_NUM_GRAN_DEF,
  parameter int NUM_BUF  = MP2_NUM_BUF_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       init,
  input  logic       samp_en,
  input  logic       syn_en,
  input  logic       sample_done,
  input  logic       synth_done,
  output logic       sample_start,
  output logic       synth_start,
  output logic       sample_active,
  output logic       synth_cmpl,
  output logic [1:0] sample_buf,
  output logic [1:0] synth_buf,
  output logic [3:0] samp_cnt,
  output logic [3:0] syn_cnt
);

  localparam logic [3:0] GRAN_L   = 4'(NUM_GRAN);
  localparam logic [1:0] BUF_L    = 2'(NUM_BUF);
  localparam logic [1:0] BUF_LAST = 2'(NUM_BUF - 1);

  logic [1:0] free, filled;
  logic       samp_busy, syn_busy;
  logic       samp_done_q, syn_done_q;
  logic       samp_start_q, syn_start_q;
  logic       samp_cmpl;

  // A completion is a rising done edge while we own a run in flight.
  assign samp_cmpl     = samp_busy & sample_done & ~samp_done_q;
  assign synth_cmpl    = syn_busy & synth_done & ~syn_done_q;
  assign sample_active = samp_busy & ~sample_done;

  assign sample_start = samp_en && (samp_cnt < GRAN_L) && (free != 2'd0) &&
                        sample_done && !samp_busy && !samp_start_q;
  assign synth_start  = syn_en && (filled != 2'd0) &&
                        synth_done && !syn_busy && !syn_start_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      free         <= BUF_L;
      filled       <= 2'd0;
      samp_cnt     <= 4'd0;
      syn_cnt      <= 4'd0;
      sample_buf   <= 2'd0;
      synth_buf    <= 2'd0;
      samp_busy    <= 1'b0;
      syn_busy     <= 1'b0;
      samp_done_q  <= 1'b1;
      syn_done_q   <= 1'b1;
      samp_start_q <= 1'b0;
      syn_start_q  <= 1'b0;
    end else begin
      samp_done_q  <= sample_done;
      syn_done_q   <= synth_done;
      samp_start_q <= sample_start;
      syn_start_q  <= synth_start;
      if (init) begin
        free       <= BUF_L;
        filled     <= 2'd0;
        samp_cnt   <= 4'd0;
        syn_cnt    <= 4'd0;
        sample_buf <= 2'd0;
        synth_buf  <= 2'd0;
        samp_busy  <= 1'b0;
        syn_busy   <= 1'b0;
      end else begin
        // Same-cycle start and completion cancel on each counter.
        free     <= free + 2'(synth_cmpl) - 2'(sample_start);
        filled   <= filled + 2'(samp_cmpl) - 2'(synth_start);
        samp_cnt <= samp_cnt + 4'(samp_cmpl);
        syn_cnt  <= syn_cnt + 4'(synth_cmpl);
        if (sample_start) begin
          samp_busy  <= 1'b1;
          sample_buf <= mp2_buf_next(sample_buf, BUF_LAST);
        end else if (samp_cmpl) begin
          samp_busy <= 1'b0;
        end
        if (synth_start) begin
          syn_busy  <= 1'b1;
          synth_buf <= mp2_buf_next(synth_buf, BUF_LAST);
        end else if (synth_cmpl) begin
          syn_busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mp2_frame_ctrl.sv
// MP2 Layer II frame sequencer: header/alloc/scalefactor stages, then overlapped
// sample decode and synthesis granules; owns the bitstream shift-enable mux.
module mp2_frame_ctrl
  import mp2_frame_ctrl_pkg::*;
#(
  parameter int NUM_GRAN = MP2_NUM_GRAN_DEF,
  parameter int NUM_BUF  = MP2_NUM_BUF_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             Frame_Start_I,
  output logic             Frame_Done_O,
  output logic             Format_Error_O,
  output logic             Header_Start_O,
  output logic             Alloc_Start_O,
  output logic             Scf_Start_O,
  output logic             Sample_Start_O,
  output logic             Synth_Start_O,
  input  logic             Header_Done_I,
  input  logic             Alloc_Done_I,
  input  logic             Scf_Done_I,
  input  logic             Sample_Done_I,
  input  logic             Synth_Done_I,
  input  logic             Format_Check_I,
  input  logic [1:0]       Header_Shift_En_I,
  input  logic [1:0]       Alloc_Shift_En_I,
  input  logic [1:0]       Scf_Shift_En_I,
  input  logic [1:0]       Sample_Shift_En_I,
  output logic [1:0]       Shift_En_O,
  output logic [3:0]       Granule_O,
  output logic [1:0]       Synth_Buf_O,
  output logic [1:0]       Sample_Buf_O,
  output mp2_frame_state_t dbg_state
);

  localparam logic [3:0] GRAN_L = 4'(NUM_GRAN);

  mp2_frame_state_t state, state_nxt;
  logic             go_q, init;
  logic             samp_en, syn_en, sample_active, synth_cmpl;
  logic [3:0]       samp_cnt, syn_cnt;

  assign samp_en      = (state == MP2_FRAME_GRAN);
  assign syn_en       = (state == MP2_FRAME_GRAN) || (state == MP2_FRAME_DRAIN);
  assign Frame_Done_O = (state == MP2_FRAME_IDLE);
  assign Granule_O    = samp_cnt;
  assign dbg_state    = state;

  mp2_buf_credit #(.NUM_GRAN(NUM_GRAN), .NUM_BUF(NUM_BUF)) u_credit (
    .clock        (clock),
    .resetn       (resetn),
    .init         (init),
    .samp_en      (samp_en),
    .syn_en       (syn_en),
    .sample_done  (Sample_Done_I),
    .synth_done   (Synth_Done_I),
    .sample_start (Sample_Start_O),
    .synth_start  (Synth_Start_O),
    .sample_active(sample_active),
    .synth_cmpl   (synth_cmpl),
    .sample_buf   (Sample_Buf_O),
    .synth_buf    (Synth_Buf_O),
    .samp_cnt     (samp_cnt),
    .syn_cnt      (syn_cnt)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= MP2_FRAME_IDLE;
      go_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      go_q  <= Header_Start_O | Alloc_Start_O | Scf_Start_O;
    end
  end

  // go_q masks the first WAIT cycle: a stage's done may not have dropped yet.
  always_comb begin
    state_nxt      = state;
    init           = 1'b0;
    Format_Error_O = 1'b0;
    Header_Start_O = 1'b0;
    Alloc_Start_O  = 1'b0;
    Scf_Start_O    = 1'b0;
    case (state)
      MP2_FRAME_IDLE: begin
        if (Frame_Start_I) begin
          state_nxt = MP2_FRAME_HDR_GO;
          init      = 1'b1;
        end
      end
      MP2_FRAME_HDR_GO: begin
        Header_Start_O = 1'b1;
        state_nxt      = MP2_FRAME_HDR_WAIT;
      end
      MP2_FRAME_HDR_WAIT: begin
        if (!go_q && Header_Done_I) begin
          if (Format_Check_I) begin
            state_nxt = MP2_FRAME_ALLOC_GO;
          end else begin
            Format_Error_O = 1'b1;
            state_nxt      = MP2_FRAME_HDR_GO;
          end
        end
      end
      MP2_FRAME_ALLOC_GO: begin
        Alloc_Start_O = 1'b1;
        state_nxt     = MP2_FRAME_ALLOC_WAIT;
      end
      MP2_FRAME_ALLOC_WAIT: begin
        if (!go_q && Alloc_Done_I) state_nxt = MP2_FRAME_SCF_GO;
      end
      MP2_FRAME_SCF_GO: begin
        Scf_Start_O = 1'b1;
        state_nxt   = MP2_FRAME_SCF_WAIT;
      end
      MP2_FRAME_SCF_WAIT: begin
        if (!go_q && Scf_Done_I) state_nxt = MP2_FRAME_GRAN;
      end
      MP2_FRAME_GRAN: begin
        if (samp_cnt == GRAN_L) state_nxt = MP2_FRAME_DRAIN;
      end
      MP2_FRAME_DRAIN: begin
        // Count this cycle's completion so IDLE follows the last synth done by one edge.
        if (((syn_cnt + 4'(synth_cmpl)) == GRAN_L) && Synth_Done_I) state_nxt = MP2_FRAME_IDLE;
      end
      default: state_nxt = MP2_FRAME_IDLE;
    endcase
  end

  always_comb begin
    Shift_En_O = MP2_SHIFT_NONE;
    case (state)
      MP2_FRAME_HDR_GO, MP2_FRAME_HDR_WAIT:     Shift_En_O = Header_Shift_En_I;
      MP2_FRAME_ALLOC_GO, MP2_FRAME_ALLOC_WAIT: Shift_En_O = Alloc_Shift_En_I;
      MP2_FRAME_SCF_GO, MP2_FRAME_SCF_WAIT:     Shift_En_O = Scf_Shift_En_I;
      MP2_FRAME_GRAN: if (sample_active) Shift_En_O = Sample_Shift_En_I;
      default:                                  Shift_En_O = MP2_SHIFT_NONE;
    endcase
  end

endmodule
